// File: rtl/dot_acc_stage.sv
// Accumulates the multiply-add pipeline's per-cycle C into one dot product per vector
// and queues finished results, throttling input so every in-flight last has a slot.
module dot_acc_stage #(
   parameter int LAT       = 2,
   parameter int W         = 32,
   parameter int RES_DEPTH = 2,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   input  logic             i_in_last,
   output logic             o_in_ready,
   input  logic [W-1:0]     i_c_in,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [W-1:0]     o_res_data,
   output logic [CNT_W-1:0] o_res_count,
   output logic             o_res_ovf
);
   localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int CW = $clog2(RES_DEPTH + 1);

   logic [LAT-1:0]   r_tag_v;
   logic [LAT-1:0]   r_tag_l;
   logic [W-1:0]     r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic [W-1:0]     r_mem_d [RES_DEPTH];
   logic [CNT_W-1:0] r_mem_c [RES_DEPTH];
   logic             r_mem_o [RES_DEPTH];
   logic [PW-1:0]    r_wp;
   logic [PW-1:0]    r_rp;
   logic [CW-1:0]    r_fcnt;
   logic [CW-1:0]    r_lif;

   logic             w_fire;
   logic             w_tv;
   logic             w_tl;
   logic [W:0]       w_sum;
   logic [W-1:0]     w_acc_nxt;
   logic             w_ovf_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_push;
   logic             w_pop;

   assign w_fire    = i_in_valid & o_in_ready;
   assign w_tv      = r_tag_v[LAT-1];
   assign w_tl      = r_tag_l[LAT-1];
   assign w_sum     = {1'b0, r_acc} + {1'b0, i_c_in};
   assign w_acc_nxt = w_sum[W-1:0];
   assign w_ovf_nxt = r_ovf | w_sum[W];
   assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_push    = w_tv & w_tl;
   assign w_pop     = o_res_valid & i_res_ready;

   // Queued results plus lasts still in the tag line must fit, so a push never meets a full FIFO.
   assign o_in_ready  = ({1'b0, r_fcnt} + {1'b0, r_lif}) < (CW+1)'(RES_DEPTH);
   assign o_res_valid = (r_fcnt != '0);
   assign o_res_data  = o_res_valid ? r_mem_d[r_rp] : '0;
   assign o_res_count = o_res_valid ? r_mem_c[r_rp] : '0;
   assign o_res_ovf   = o_res_valid & r_mem_o[r_rp];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tag_v <= '0;
         r_tag_l <= '0;
      end else begin
         r_tag_v[0] <= w_fire;
         r_tag_l[0] <= w_fire & i_in_last;
         for (int i = 1; i < LAT; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_l[i] <= r_tag_l[i-1];
         end
      end
   end

   // c_in is only trusted under a valid tag; startup garbage is never summed.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_tv) begin
         if (w_tl) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_d[r_wp] <= w_acc_nxt;
         r_mem_c[r_wp] <= w_cnt_nxt;
         r_mem_o[r_wp] <= w_ovf_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_fcnt <= '0;
         r_lif  <= '0;
      end else begin
         if (w_push) r_wp <= (r_wp == PW'(RES_DEPTH-1)) ? '0 : r_wp + PW'(1);
         if (w_pop)  r_rp <= (r_rp == PW'(RES_DEPTH-1)) ? '0 : r_rp + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + CW'(1);
            2'b01:   r_fcnt <= r_fcnt - CW'(1);
            default: r_fcnt <= r_fcnt;
         endcase
         case ({w_fire & i_in_last, w_push})
            2'b10:   r_lif <= r_lif + CW'(1);
            2'b01:   r_lif <= r_lif - CW'(1);
            default: r_lif <= r_lif;
         endcase
      end
   end
endmodule

// File: tb/tb_dot_acc_stage.sv
// Bench for dot_acc_stage: directed scenarios plus randomized vectors, all scored
// against a per-vector reference built from the terms that actually fired.
module tb_dot_acc_stage;
   localparam int LAT       = 2;
   localparam int W         = 32;
   localparam int RES_DEPTH = 2;
   localparam int CNT_W     = 16;

   typedef struct packed {
      logic [W-1:0]     d;
      logic [CNT_W-1:0] c;
      logic             o;
   } res_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             res_ready = 1'b0;
   logic             in_ready;
   logic             res_valid;
   logic             res_ovf;
   logic [W-1:0]     c_in;
   logic [W-1:0]     res_data;
   logic [CNT_W-1:0] res_count;
   logic [W-1:0]     op_c = '0;
   logic [W-1:0]     cp [LAT] = '{default: '0};

   int               nchk = 0;
   int               nerr = 0;
   int               outstanding = 0;
   int               npop = 0;
   logic [W-1:0]     cur [$];
   res_t             exp_q [$];
   res_t             e;

   always #5 clk = ~clk;

   // Stand-in for the un-stallable multiply-add pipeline: C appears LAT edges after its operands.
   always @(posedge clk) begin
      cp[0] <= op_c;
      for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
   end
   assign c_in = cp[LAT-1];

   dot_acc_stage #(.LAT(LAT), .W(W), .RES_DEPTH(RES_DEPTH), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_last(in_last),
      .o_in_ready(in_ready), .i_c_in(c_in), .o_res_valid(res_valid), .i_res_ready(res_ready),
      .o_res_data(res_data), .o_res_count(res_count), .o_res_ovf(res_ovf)
   );

   function automatic res_t ref_vec(input logic [W-1:0] t[$]);
      longint unsigned tot = 0;
      res_t r;
      foreach (t[i]) tot += 64'(t[i]);
      r.d = tot[W-1:0];
      r.o = (tot >> W) != 0;
      r.c = (t.size() >= (1 << CNT_W) - 1) ? '1 : CNT_W'(t.size());
      return r;
   endfunction

   // Outstanding = lasts accepted but not yet consumed downstream; in_ready must track it exactly.
   always @(negedge clk) begin
      if (rst_n) begin
         nchk++;
         if (in_ready !== (outstanding < RES_DEPTH)) begin
            nerr++;
            $display("FAIL in_ready: got %b want %b (outstanding %0d)", in_ready, outstanding < RES_DEPTH, outstanding);
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            cur.push_back(op_c);
            if (in_last) begin
               exp_q.push_back(ref_vec(cur));
               cur.delete();
               outstanding++;
            end
         end
         if (res_valid === 1'b1 && res_ready === 1'b1) begin
            nchk++;
            if (exp_q.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_result: got data=%h count=%0d with none pending", res_data, res_count);
            end else begin
               e = exp_q.pop_front();
               if ({res_data, res_count, res_ovf} !== e) begin
                  nerr++;
                  $display("FAIL result: got d=%h c=%0d o=%b want d=%h c=%0d o=%b",
                           res_data, res_count, res_ovf, e.d, e.c, e.o);
               end
            end
            outstanding--;
            npop++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      op_c     = $urandom;
   endtask

   task automatic beat(input logic [W-1:0] c, input bit last);
      int k;
      in_valid = 1'b1;
      in_last  = last;
      op_c     = c;
      for (k = 0; k < 50 && in_ready !== 1'b1; k++) cyc();
      if (k == 50) begin
         nerr++;
         $display("FAIL beat_timeout: in_ready=%b want 1 within 50 cycles", in_ready);
      end
      cyc();
      idle();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (res_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain();
      cyc();
      res_ready = 1'b1;
      for (int k = 0; k < 60 && (outstanding != 0 || exp_q.size() != 0); k++) cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      res_ready = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      @(negedge clk);
      nchk += 5;
      if (res_valid !== 1'b0) begin nerr++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
      if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      if (res_data !== '0) begin nerr++; $display("FAIL rst_res_data: got %h want 0", res_data); end
      if (res_count !== '0) begin nerr++; $display("FAIL rst_res_count: got %0d want 0", res_count); end
      if (res_ovf !== 1'b0) begin nerr++; $display("FAIL rst_res_ovf: got %b want 0", res_ovf); end
      cyc();
   endtask

   task automatic test_basic();
      res_ready = 1'b1;
      beat(5, 0);
      beat(7, 0);
      beat(11, 1);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         nchk++;
         if (res_valid !== (k == LAT + 1)) begin
            nerr++;
            $display("FAIL basic_valid_t%0d: got %b want %b", k, res_valid, k == LAT + 1);
         end
         if (k == LAT + 1) begin
            nchk++;
            if ({res_data, res_count, res_ovf} !== {32'd23, 16'd3, 1'b0}) begin
               nerr++;
               $display("FAIL basic_result: got d=%0d c=%0d o=%b want 23/3/0", res_data, res_count, res_ovf);
            end
         end
      end
      drain();
      nchk++;
      if (outstanding != 0 || exp_q.size() != 0) begin nerr++; $display("FAIL basic_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_overflow();
      bit ok;
      res_ready = 1'b1;
      beat(32'hFFFF_FFF0, 0);
      beat(32'h20, 1);
      wait_valid(ok);
      nchk++;
      if (!ok || {res_data, res_count, res_ovf} !== {32'h10, 16'd2, 1'b1}) begin
         nerr++;
         $display("FAIL ovf_result: got v=%b d=%h c=%0d o=%b want 10/2/1", ok, res_data, res_count, res_ovf);
      end
      cyc();
      beat(4, 1);
      wait_valid(ok);
      nchk++;
      if (!ok || {res_data, res_count, res_ovf} !== {32'd4, 16'd1, 1'b0}) begin
         nerr++;
         $display("FAIL ovf_next: got v=%b d=%h c=%0d o=%b want 4/1/0", ok, res_data, res_count, res_ovf);
      end
      drain();
      nchk++;
      if (outstanding != 0 || exp_q.size() != 0) begin nerr++; $display("FAIL ovf_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int p0;
      int k;
      cyc();
      res_ready = 1'b0;
      p0 = npop;
      beat(1, 1);
      beat(2, 1);
      in_valid = 1'b1;
      in_last  = 1'b1;
      op_c     = 3;
      @(negedge clk);
      nchk++;
      if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_drop: got %b want 0", in_ready); end
      repeat (LAT + 3) cyc();
      @(negedge clk);
      nchk++;
      if (res_valid !== 1'b1 || res_data !== 32'd1 || in_ready !== 1'b0) begin
         nerr++;
         $display("FAIL bp_hold: got v=%b d=%0d rdy=%b want 1/1/0", res_valid, res_data, in_ready);
      end
      cyc();
      res_ready = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
      end
      nchk++;
      if (k == 20) begin nerr++; $display("FAIL bp_ready_rise: got in_ready=%b want 1 within 20 cycles", in_ready); end
      cyc();
      idle();
      drain();
      nchk += 2;
      if (npop - p0 != 3) begin nerr++; $display("FAIL bp_pop_count: got %0d want 3", npop - p0); end
      if (outstanding != 0 || exp_q.size() != 0) begin nerr++; $display("FAIL bp_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_gaps();
      bit ok;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b0;
         in_last  = 1'($urandom_range(0, 1));
         op_c     = $urandom;
         cyc();
         beat(1, i == 3);
      end
      wait_valid(ok);
      nchk++;
      if (!ok || {res_data, res_count, res_ovf} !== {32'd4, 16'd4, 1'b0}) begin
         nerr++;
         $display("FAIL gaps_result: got v=%b d=%0d c=%0d o=%b want 4/4/0", ok, res_data, res_count, res_ovf);
      end
      drain();
      nchk++;
      if (outstanding != 0 || exp_q.size() != 0) begin nerr++; $display("FAIL gaps_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_push_pop();
      cyc();
      res_ready = 1'b0;
      beat(10, 1);
      repeat (LAT + 1) cyc();
      beat(20, 1);
      repeat (LAT - 1) cyc();
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
      @(negedge clk);
      nchk++;
      if (res_valid !== 1'b1 || res_data !== 32'd20 || res_count !== 16'd1) begin
         nerr++;
         $display("FAIL pp_head: got v=%b d=%0d c=%0d want 1/20/1", res_valid, res_data, res_count);
      end
      cyc();
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
      @(negedge clk);
      nchk++;
      if (res_valid !== 1'b0) begin nerr++; $display("FAIL pp_single_entry: got res_valid=%b want 0", res_valid); end
      drain();
      nchk++;
      if (outstanding != 0 || exp_q.size() != 0) begin nerr++; $display("FAIL pp_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      cyc();
      res_ready = 1'b0;
      beat(3, 1);
      beat(1, 0);
      beat(2, 0);
      rst_n = 1'b0;
      idle();
      cyc();
      cur.delete();
      exp_q.delete();
      outstanding = 0;
      rst_n = 1'b1;
      @(negedge clk);
      nchk++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
         nerr++;
         $display("FAIL midrst_state: got v=%b rdy=%b want 0/1", res_valid, in_ready);
      end
      cyc();
      beat(9, 1);
      wait_valid(ok);
      nchk++;
      if (!ok || {res_data, res_count, res_ovf} !== {32'd9, 16'd1, 1'b0}) begin
         nerr++;
         $display("FAIL midrst_fresh: got v=%b d=%0d c=%0d o=%b want 9/1/0", ok, res_data, res_count, res_ovf);
      end
      drain();
      nchk++;
      if (outstanding != 0 || exp_q.size() != 0) begin nerr++; $display("FAIL midrst_drain: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_random();
      int len;
      int k;
      cyc();
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 5);
         for (int t = 0; t < len; t++) begin
            if ($urandom_range(0, 2) == 0) begin
               idle();
               res_ready = 1'($urandom_range(0, 1));
               cyc();
            end
            in_valid = 1'b1;
            in_last  = (t == len - 1);
            op_c     = $urandom;
            for (k = 0; k < 100 && in_ready !== 1'b1; k++) begin
               res_ready = 1'($urandom_range(0, 1));
               cyc();
            end
            if (k == 100) begin nerr++; $display("FAIL rand_stall: in_ready=%b want 1 within 100 cycles", in_ready); end
            res_ready = 1'($urandom_range(0, 1));
            cyc();
         end
      end
      idle();
      drain();
      @(negedge clk);
      nchk += 2;
      if (outstanding != 0 || exp_q.size() != 0) begin nerr++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); end
      if (res_valid !== 1'b0) begin nerr++; $display("FAIL rand_empty: got res_valid=%b want 0", res_valid); end
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_gaps();
      test_push_pop();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
